// File: rtl/esc_pwm_encoder.sv
// esc_pwm_encoder: per-motor PWM transmitter for ESC/servo drive.
// Accepts microsecond width commands over valid/ready, clamps them to a
// safe window, and emits one glitch-free pulse per fixed-period frame.
// New widths take effect only at frame boundaries; if commands stop
// arriving for TIMEOUT_FRAMES frames the output falls back to DISARM_US.
module esc_pwm_encoder #(
  parameter int CLK_DIV        = 50,
  parameter int FRAME_US       = 2500,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int DISARM_US      = 1000,
  parameter int TIMEOUT_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [15:0] i_us,
  output logic        o_pwm,
  output logic        o_frame_start,
  output logic [15:0] o_active_us,
  output logic        o_clamped,
  output logic        o_failsafe
);

  // Prescaler width; a divide-by-one still needs a one-bit counter.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0]      MIN_W      = 16'(MIN_US);
  localparam logic [15:0]      MAX_W      = 16'(MAX_US);
  localparam logic [15:0]      DISARM_W   = 16'(DISARM_US);
  localparam logic [15:0]      TIMEOUT_W  = 16'(TIMEOUT_FRAMES);

  // S_IDLE is only occupied while in reset; the first edge out of reset
  // opens frame 0 exactly like a regular frame boundary.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  // Clamp a commanded width into [MIN_US, MAX_US].
  function automatic logic [15:0] clamp_us(input logic [15:0] x);
    logic [15:0] r;
    if (x < MIN_W) begin
      r = MIN_W;
    end else if (x > MAX_W) begin
      r = MAX_W;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // True when a commanded width lies outside the safe window.
  function automatic logic out_of_range(input logic [15:0] x);
    return (x < MIN_W) || (x > MAX_W);
  endfunction

  state_e             state_q,       state_d;
  logic [DIV_W-1:0]   div_cnt_q,     div_cnt_d;
  logic [15:0]        us_cnt_q,      us_cnt_d;
  logic               full_q,        full_d;
  logic [15:0]        slot_q,        slot_d;
  logic [15:0]        miss_q,        miss_d;
  logic [15:0]        active_q,      active_d;
  logic               clamped_q,     clamped_d;
  logic               failsafe_q,    failsafe_d;
  logic               pwm_q,         pwm_d;
  logic               frame_start_q, frame_start_d;
  logic               ready_q,       ready_d;

  logic               running;
  logic               us_tick;
  logic               boundary;
  logic               fall_point;
  logic               xfer;
  logic [15:0]        miss_inc;

  // Microsecond prescaler and frame counter; both hold at zero until frame 0 starts.
  always_comb begin
    running   = (state_q != S_IDLE);
    us_tick   = running && (div_cnt_q == DIV_LAST);
    boundary  = us_tick && (us_cnt_q == FRAME_LAST);
    div_cnt_d = div_cnt_q;
    us_cnt_d  = us_cnt_q;
    if (!running) begin
      div_cnt_d = '0;
      us_cnt_d  = 16'd0;
    end else if (us_tick) begin
      div_cnt_d = '0;
      if (boundary) begin
        us_cnt_d = 16'd0;
      end else begin
        us_cnt_d = us_cnt_q + 16'd1;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Pending command slot, miss counter and the per-frame width latch.
  always_comb begin
    xfer       = i_valid && ready_q;
    miss_inc   = (miss_q >= TIMEOUT_W) ? TIMEOUT_W : (miss_q + 16'd1);
    full_d     = full_q;
    slot_d     = slot_q;
    miss_d     = miss_q;
    active_d   = active_q;
    clamped_d  = clamped_q;
    failsafe_d = failsafe_q;
    // The boundary looks at the slot as it was before this edge, so a
    // command accepted on the boundary cycle itself waits one more frame.
    if (boundary) begin
      if (full_q) begin
        active_d   = clamp_us(slot_q);
        clamped_d  = out_of_range(slot_q);
        full_d     = 1'b0;
        miss_d     = 16'd0;
        failsafe_d = 1'b0;
      end else begin
        miss_d = miss_inc;
        if (miss_inc == TIMEOUT_W) begin
          active_d   = DISARM_W;
          clamped_d  = 1'b0;
          failsafe_d = 1'b1;
        end else begin
          active_d = active_q;
        end
      end
    end else begin
      miss_d = miss_q;
    end
    // ready_q is low whenever full_q is set, so this never overwrites.
    if (xfer) begin
      full_d = 1'b1;
      slot_d = i_us;
    end else begin
      slot_d = slot_d;
    end
    ready_d = !full_d;
  end

  // Pulse FSM: rise at each frame boundary, fall after active_us microseconds.
  always_comb begin
    fall_point    = us_tick && (us_cnt_q == (active_q - 16'd1));
    state_d       = state_q;
    frame_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d       = S_HIGH;
        frame_start_d = 1'b1;
      end
      S_HIGH: begin
        if (fall_point) begin
          state_d = S_LOW;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (boundary) begin
          state_d       = S_HIGH;
          frame_start_d = 1'b1;
        end else begin
          state_d = S_LOW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    pwm_d = (state_d == S_HIGH);
  end

  // Timebase and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      us_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      us_cnt_q  <= us_cnt_d;
    end
  end

  // Command slot and failsafe bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= 1'b0;
      slot_q     <= 16'd0;
      miss_q     <= TIMEOUT_W;
      active_q   <= DISARM_W;
      clamped_q  <= 1'b0;
      failsafe_q <= 1'b1;
    end else begin
      full_q     <= full_d;
      slot_q     <= slot_d;
      miss_q     <= miss_d;
      active_q   <= active_d;
      clamped_q  <= clamped_d;
      failsafe_q <= failsafe_d;
    end
  end

  // Registered pin-level outputs so the motor line cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
      ready_q       <= ready_d;
    end
  end

  assign o_pwm         = pwm_q;
  assign o_frame_start = frame_start_q;
  assign o_ready       = ready_q;
  assign o_active_us   = active_q;
  assign o_clamped     = clamped_q;
  assign o_failsafe    = failsafe_q;

endmodule
